// File: rtl/regfile_mp_sb.sv
// Multi-port register file with registered reads, one write port, optional
// write-to-read bypass, optional hardwired-zero r0 and a busy scoreboard
// that issue logic uses to detect RAW hazards.
module regfile_mp_sb #(
   parameter int DATA_WIDTH   = 32,
   parameter int NUM_REGS     = 32,
   parameter int NUM_RD_PORTS = 2,
   parameter int BYPASS       = 1,
   parameter int ZERO_REG0    = 1,
   localparam int ADDR_W      = $clog2(NUM_REGS)
) (
   input  logic                               clk,
   input  logic                               reset_n,
   input  logic [NUM_RD_PORTS-1:0]            rd_en,
   input  logic [NUM_RD_PORTS*ADDR_W-1:0]     rd_addr,
   output logic [NUM_RD_PORTS*DATA_WIDTH-1:0] rd_data,
   output logic [NUM_RD_PORTS-1:0]            rd_valid,
   output logic [NUM_RD_PORTS-1:0]            rd_busy,
   input  logic                               wr_en,
   input  logic [ADDR_W-1:0]                  wr_addr,
   input  logic [DATA_WIDTH-1:0]              wr_data,
   input  logic                               rsv_en,
   input  logic [ADDR_W-1:0]                  rsv_addr,
   output logic [ADDR_W:0]                    busy_count
);

   localparam logic [ADDR_W:0] NUM_REGS_V = (ADDR_W+1)'(NUM_REGS);
   localparam logic [ADDR_W:0] CNT_ONE    = (ADDR_W+1)'(1);

   // An address is "live" when it names a real, writable register.
   function automatic logic addr_live(input logic [ADDR_W-1:0] a);
      return ({1'b0, a} < NUM_REGS_V) && !((ZERO_REG0 != 0) && (a == '0));
   endfunction

   logic [DATA_WIDTH-1:0] regs [NUM_REGS];
   logic [NUM_REGS-1:0]   busy;
   logic [NUM_REGS-1:0]   busy_mid;
   logic [NUM_REGS-1:0]   busy_next;
   logic                  wr_ok;
   logic                  rsv_ok;
   logic                  bit_set;
   logic                  bit_clr;
   logic [ADDR_W-1:0]     rd_a     [NUM_RD_PORTS];
   logic [DATA_WIDTH-1:0] rd_val   [NUM_RD_PORTS];
   logic [NUM_RD_PORTS-1:0] rd_bsy_n;

   // Scoreboard next state: release on write first, then reserve, so a
   // simultaneous reserve wins. bit_set/bit_clr drive the incremental count.
   always_comb begin
      wr_ok    = wr_en && addr_live(wr_addr);
      rsv_ok   = rsv_en && addr_live(rsv_addr);
      busy_mid = busy;
      bit_clr  = 1'b0;
      if (wr_ok) begin
         bit_clr           = busy[wr_addr];
         busy_mid[wr_addr] = 1'b0;
      end
      busy_next = busy_mid;
      bit_set   = 1'b0;
      if (rsv_ok) begin
         bit_set             = !busy_mid[rsv_addr];
         busy_next[rsv_addr] = 1'b1;
      end
   end

   // Per-port read value and busy bit, including optional same-cycle bypass.
   always_comb begin
      for (int i = 0; i < NUM_RD_PORTS; i++) begin
         rd_a[i]     = rd_addr[i*ADDR_W +: ADDR_W];
         rd_val[i]   = '0;
         rd_bsy_n[i] = 1'b0;
         if (addr_live(rd_a[i])) begin
            if ((BYPASS != 0) && wr_ok && (wr_addr == rd_a[i]))
               rd_val[i] = wr_data;
            else
               rd_val[i] = regs[rd_a[i]];
            rd_bsy_n[i] = busy_next[rd_a[i]];
         end
      end
   end

   // Register array write.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
      end else if (wr_ok) begin
         regs[wr_addr] <= wr_data;
      end
   end

   // Busy bits and their running population count.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         busy       <= '0;
         busy_count <= '0;
      end else begin
         busy <= busy_next;
         case ({bit_set, bit_clr})
            2'b10:   busy_count <= busy_count + CNT_ONE;
            2'b01:   busy_count <= busy_count - CNT_ONE;
            default: busy_count <= busy_count;
         endcase
      end
   end

   // Registered read ports; data and busy hold when a port is idle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_data  <= '0;
         rd_valid <= '0;
         rd_busy  <= '0;
      end else begin
         rd_valid <= rd_en;
         for (int i = 0; i < NUM_RD_PORTS; i++) begin
            if (rd_en[i]) begin
               rd_data[i*DATA_WIDTH +: DATA_WIDTH] <= rd_val[i];
               rd_busy[i]                          <= rd_bsy_n[i];
            end
         end
      end
   end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Bench for regfile_mp_sb: two instances share one stimulus stream.
// Instance 0 uses defaults (bypass, hardwired r0); instance 1 has 20
// registers (so addresses 20..31 are out of range), no bypass, writable r0.
module tb_regfile_mp_sb;

   logic        clk;
   logic        reset_n;
   logic [1:0]  rd_en;
   logic [9:0]  rd_addr;
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
   logic        rsv_en;
   logic [4:0]  rsv_addr;

   logic [63:0] rd_data_o    [2];
   logic [1:0]  rd_valid_o   [2];
   logic [1:0]  rd_busy_o    [2];
   logic [5:0]  busy_count_o [2];

   int checks   = 0;
   int failures = 0;

   regfile_mp_sb u_dut0 (
      .clk(clk), .reset_n(reset_n),
      .rd_en(rd_en), .rd_addr(rd_addr),
      .rd_data(rd_data_o[0]), .rd_valid(rd_valid_o[0]), .rd_busy(rd_busy_o[0]),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rsv_en(rsv_en), .rsv_addr(rsv_addr),
      .busy_count(busy_count_o[0])
   );

   regfile_mp_sb #(
      .DATA_WIDTH(32), .NUM_REGS(20), .NUM_RD_PORTS(2), .BYPASS(0), .ZERO_REG0(0)
   ) u_dut1 (
      .clk(clk), .reset_n(reset_n),
      .rd_en(rd_en), .rd_addr(rd_addr),
      .rd_data(rd_data_o[1]), .rd_valid(rd_valid_o[1]), .rd_busy(rd_busy_o[1]),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rsv_en(rsv_en), .rsv_addr(rsv_addr),
      .busy_count(busy_count_o[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: architectural contents plus expected port outputs.
   int          cfg_n  [2] = '{32, 20};
   int          cfg_bp [2] = '{1, 0};
   int          cfg_z  [2] = '{1, 0};
   logic [31:0] m_regs [2][32];
   bit          m_busy [2][32];
   logic [31:0] m_rdd  [2][2];
   bit          m_rdv  [2][2];
   bit          m_rdb  [2][2];

   function automatic bit m_live(int k, int a);
      return (a < cfg_n[k]) && !(cfg_z[k] != 0 && a == 0);
   endfunction

   function automatic int m_count(int k);
      int c = 0;
      for (int r = 0; r < 32; r++) c += int'(m_busy[k][r]);
      return c;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         for (int r = 0; r < 32; r++) begin
            m_regs[k][r] = '0;
            m_busy[k][r] = 1'b0;
         end
         for (int p = 0; p < 2; p++) begin
            m_rdd[k][p] = '0;
            m_rdv[k][p] = 1'b0;
            m_rdb[k][p] = 1'b0;
         end
      end
   endtask

   // Apply one clock edge's worth of the behavioural rules to the model.
   task automatic model_edge();
      for (int k = 0; k < 2; k++) begin
         bit w_ok = wr_en && m_live(k, int'(wr_addr));
         bit r_ok = rsv_en && m_live(k, int'(rsv_addr));
         bit nb [32];
         for (int r = 0; r < 32; r++) nb[r] = m_busy[k][r];
         if (w_ok) nb[wr_addr] = 1'b0;
         if (r_ok) nb[rsv_addr] = 1'b1;
         for (int p = 0; p < 2; p++) begin
            int a = int'(rd_addr[p*5 +: 5]);
            m_rdv[k][p] = rd_en[p];
            if (rd_en[p]) begin
               if (!m_live(k, a))                         m_rdd[k][p] = '0;
               else if (cfg_bp[k] != 0 && w_ok && int'(wr_addr) == a) m_rdd[k][p] = wr_data;
               else                                        m_rdd[k][p] = m_regs[k][a];
               m_rdb[k][p] = (a < cfg_n[k]) ? nb[a] : 1'b0;
            end
         end
         if (w_ok) m_regs[k][wr_addr] = wr_data;
         for (int r = 0; r < 32; r++) m_busy[k][r] = nb[r];
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string where);
      for (int k = 0; k < 2; k++) begin
         for (int p = 0; p < 2; p++) begin
            chk($sformatf("%s i%0d.p%0d rd_valid", where, k, p), 32'(rd_valid_o[k][p]), 32'(m_rdv[k][p]));
            chk($sformatf("%s i%0d.p%0d rd_data", where, k, p), rd_data_o[k][p*32 +: 32], m_rdd[k][p]);
            chk($sformatf("%s i%0d.p%0d rd_busy", where, k, p), 32'(rd_busy_o[k][p]), 32'(m_rdb[k][p]));
         end
         chk($sformatf("%s i%0d busy_count", where, k), 32'(busy_count_o[k]), 32'(m_count(k)));
      end
   endtask

   task automatic idle();
      rd_en  = '0;
      wr_en  = 1'b0;
      rsv_en = 1'b0;
   endtask

   task automatic rd(input int p, input int a);
      rd_en[p]          = 1'b1;
      rd_addr[p*5 +: 5] = 5'(a);
   endtask

   task automatic wr(input int a, input logic [31:0] d);
      wr_en   = 1'b1;
      wr_addr = 5'(a);
      wr_data = d;
   endtask

   task automatic rsv(input int a);
      rsv_en   = 1'b1;
      rsv_addr = 5'(a);
   endtask

   task automatic step(input string where);
      model_edge();
      @(posedge clk);
      #1;
      check_all(where);
   endtask

   function automatic int rand_addr();
      if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, 31));
      return int'($urandom_range(0, 7));
   endfunction

   initial begin
      reset_n  = 1'b0;
      rd_addr  = '0;
      wr_addr  = '0;
      wr_data  = '0;
      rsv_addr = '0;
      idle();
      model_reset();
      #1;
      check_all("reset_t0");
      rd(0, 5);
      @(posedge clk);
      #1;
      check_all("reset_held");
      @(negedge clk);
      reset_n = 1'b1;
      idle();

      // Reads right after reset return zero.
      rd(0, 5); rd(1, 31);
      step("post_reset_read");
      chk("post_reset rd_valid", 32'(rd_valid_o[0]), 32'h3);
      chk("post_reset rd_data", rd_data_o[0][31:0], 32'h0);
      chk("post_reset busy_count", 32'(busy_count_o[0]), 32'h0);

      // Write then read back.
      idle(); wr(7, 32'hDEADBEEF);
      step("write_r7");
      idle(); rd(0, 7);
      step("read_r7");
      chk("read_r7 i0", rd_data_o[0][31:0], 32'hDEADBEEF);
      chk("read_r7 i1", rd_data_o[1][31:0], 32'hDEADBEEF);

      // Same-edge write/read: bypass instance forwards, other returns old.
      idle(); wr(3, 32'h12345678); rd(0, 3);
      step("bypass_r3");
      chk("bypass i0", rd_data_o[0][31:0], 32'h12345678);
      chk("no_bypass i1", rd_data_o[1][31:0], 32'h0);

      // r0 is inert on instance 0.
      idle(); wr(0, 32'hFFFFFFFF); rsv(0); rd(0, 0);
      step("r0_write_rsv");
      idle(); rd(0, 0);
      step("r0_read");
      chk("r0 data i0", rd_data_o[0][31:0], 32'h0);
      chk("r0 busy i0", 32'(rd_busy_o[0][0]), 32'h0);
      chk("r0 count i0", 32'(busy_count_o[0]), 32'h0);
      idle(); wr(0, 32'h0);
      step("r0_release_i1");

      // Scoreboard sequence.
      idle(); rsv(4);
      step("rsv_r4");
      chk("rsv_r4 count", 32'(busy_count_o[0]), 32'h1);
      idle(); rd(0, 4);
      step("read_busy_r4");
      chk("r4 rd_busy", 32'(rd_busy_o[0][0]), 32'h1);
      idle(); wr(4, 32'h44); rsv(4); rd(1, 4);
      step("wr_rsv_r4");
      chk("wr_rsv count", 32'(busy_count_o[0]), 32'h1);
      chk("wr_rsv rd_busy", 32'(rd_busy_o[0][1]), 32'h1);
      idle(); wr(4, 32'h45);
      step("wr_r4");
      chk("wr_r4 count", 32'(busy_count_o[0]), 32'h0);

      // Out-of-range on instance 1 (20 regs): write/reserve r25 are ignored.
      idle(); wr(25, 32'hCAFE0001); rsv(25);
      step("oor_wr");
      idle(); rd(0, 25); rd(1, 25);
      step("oor_rd");
      chk("oor data i1", rd_data_o[1][31:0], 32'h0);
      chk("oor count i1", 32'(busy_count_o[1]), 32'h0);

      // Asynchronous reset between edges while r9 is busy and holds 0xAA.
      idle(); wr(9, 32'hAA); rsv(9);
      step("setup_r9");
      idle(); rd(0, 9); rd(1, 9);
      step("read_r9");
      chk("r9 data", rd_data_o[0][31:0], 32'hAA);
      #3;
      reset_n = 1'b0;
      #1;
      model_reset();
      check_all("async_reset");
      chk("async_reset count", 32'(busy_count_o[0]), 32'h0);
      chk("async_reset valid", 32'(rd_valid_o[0]), 32'h0);
      #2;
      reset_n = 1'b1;
      idle(); rd(0, 9);
      step("after_reset_r9");
      chk("after_reset r9 data", rd_data_o[0][31:0], 32'h0);
      chk("after_reset r9 busy", 32'(rd_busy_o[0][0]), 32'h0);

      // Randomised traffic against the model.
      for (int n = 0; n < 600; n++) begin
         rd_en    = 2'($urandom);
         rd_addr  = {5'(rand_addr()), 5'(rand_addr())};
         if ($urandom_range(0, 4) == 0) rd_addr[9:5] = rd_addr[4:0];
         wr_en    = ($urandom_range(0, 2) != 0);
         wr_addr  = 5'(rand_addr());
         wr_data  = $urandom;
         rsv_en   = ($urandom_range(0, 1) != 0);
         rsv_addr = ($urandom_range(0, 3) == 0) ? wr_addr : 5'(rand_addr());
         step("random");
      end

      idle();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/regfile_mp_sb.md
Name: regfile_mp_sb

Overview:
- Parametrised, fully clocked register file for the CPU datapath.
- Replaces the single-write, two-read latch-style file with a synchronous array that has:
  - N registered read ports and one write port;
  - optional write-to-read bypass;
  - optional hardwired-zero register 0;
  - a per-register busy scoreboard used by issue logic to detect RAW hazards.
- Sits between decode/issue (read, reserve) and writeback (write, release).

Parameters:
- DATA_WIDTH, 32: width of each register and of all data ports.
- NUM_REGS, 32: number of architectural registers, 2..256.
- NUM_RD_PORTS, 2: number of independent read ports, 1..4.
- BYPASS, 1: 1 = a same-cycle write to the read address is forwarded to the read data; 0 = the read returns the pre-write value.
- ZERO_REG0, 1: 1 = register 0 always reads 0, and writes and reserves to it are ignored.
- Local parameter ADDR_W = clog2(NUM_REGS).

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- rd_en  in  NUM_RD_PORTS  per-port read request.
- rd_addr  in  NUM_RD_PORTS*ADDR_W  read addresses; port i occupies bits [i*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD_PORTS*DATA_WIDTH  registered read data, packed the same way.
- rd_valid  out  NUM_RD_PORTS  rd_data for port i is valid this cycle.
- rd_busy  out  NUM_RD_PORTS  registered scoreboard bit of the address read on port i.
- wr_en  in  1  write enable; also releases the busy bit of the written register.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_WIDTH  write data.
- rsv_en  in  1  reserve request from issue; sets the busy bit.
- rsv_addr  in  ADDR_W  register to reserve.
- busy_count  out  ADDR_W+1  number of registers currently busy.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low.
  - While reset_n = 0: all registers = 0, all busy bits = 0, rd_data = 0, rd_valid = 0, rd_busy = 0, busy_count = 0.
  - Reset asserted mid-operation discards all in-flight reads, writes and reservations immediately, with no clock required.
  - Normal operation resumes on the first rising edge after reset_n goes high.
- Write, at the rising edge when wr_en = 1:
  - Normal case: regs[wr_addr] <= wr_data.
  - Ignored when ZERO_REG0 = 1 and wr_addr = 0.
  - Ignored when wr_addr >= NUM_REGS.
- Read, 1-cycle latency; each port is independent:
  - If rd_en[i] = 1 at edge k: in cycle k+1, rd_valid[i] = 1 and rd_data[i] = regs[rd_addr_i] as sampled at edge k.
  - Same-cycle write to that address: with BYPASS = 1, rd_data returns wr_data; with BYPASS = 0, it returns the old value.
  - Register 0 with ZERO_REG0 = 1, or an out-of-range address: rd_data = 0.
  - If rd_en[i] = 0: rd_valid[i] = 0 and rd_data[i] and rd_busy[i] hold their previous values.
  - Multiple ports reading the same address in the same cycle all return identical data.
- Scoreboard:
  - busy_next = busy, with busy[wr_addr] cleared if wr_en, then busy[rsv_addr] set if rsv_en.
  - Simultaneous reserve and write to the same address: the reserve wins, so the bit ends at 1.
  - Reserve on a register that is already busy: no change and no error.
  - Write on a register that is not busy: the data is written and the bit stays 0.
  - Reserve or write to register 0 (ZERO_REG0 = 1) or to an out-of-range address: the busy bit is unaffected.
  - rd_busy[i] <= busy_next[rd_addr_i] when rd_en[i] = 1, so rd_busy is consistent with the bypassed data.
- busy_count:
  - Registered; always equals popcount(busy).
  - Updated incrementally by -1, 0 or +1 per cycle.
  - Never wraps; the maximum is NUM_REGS, or NUM_REGS-1 with ZERO_REG0 = 1.
- No combinational path from any input to any output.

Test Plan:
- Reset, then read ports 0/1 at r5/r31 -> next cycle rd_data = 0, 0; rd_valid = 2'b11; busy_count = 0.
- Write r7 = 0xDEADBEEF at edge k, read r7 at edge k+1 -> rd_data = 0xDEADBEEF at cycle k+2.
- BYPASS=1: write r3 = 0x12345678 and read r3 at the same edge -> next cycle rd_data = 0x12345678. BYPASS=0: same stimulus -> the old value 0x0.
- ZERO_REG0=1: write r0 = 0xFFFFFFFF, reserve r0, read r0 -> rd_data = 0, rd_busy = 0, busy_count = 0.
- Scoreboard sequence:
  - Reserve r4 -> busy_count = 1.
  - Read r4 -> rd_busy = 1.
  - Write r4 and reserve r4 at the same edge -> busy stays 1, busy_count stays 1.
  - Write r4 alone -> busy_count = 0.
- Assert reset_n low between clock edges while r9 is busy and holds 0xAA -> outputs clear immediately; after release, reading r9 returns 0 and rd_busy = 0.
